ab_link_arbiter: RTL

Round-robin packet arbiter that shares the single A-to-B data link among NUM_REQ upstream requesters. A granted requester is held until the last beat of its packet has been accepted. Beats then pass through a one-entry registered output stage that drives the link toward moduleB. The block sits between the requester sources and the data_to_B input path of the A/B interconnect.

---
 rtl/ab_link_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ab_link_arbiter.sv
// -----------------------------------------------------------------------------
// ab_link_arbiter
//
// Round-robin packet arbiter sharing the single A-to-B data link among
// NUM_REQ upstream requesters. Once a requester is granted it keeps the link
// until the last beat of its packet has been accepted. Accepted beats pass
// through a one-entry registered output stage that drives the link.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   req_valid  in   [NUM_REQ]            per-requester beat valid
//   req_data   in   [NUM_REQ*DATA_WIDTH] flattened beats, requester i at
//                                        [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last   in   [NUM_REQ]            per-requester last-beat flag
//   req_ready  out  [NUM_REQ]            per-requester beat accept
//   out_valid  out                       link beat valid
//   out_data   out  [DATA_WIDTH]         link beat data
//   out_last   out                       link last-beat flag
//   out_src    out  [ID_WIDTH]           requester that produced the beat
//   out_ready  in                        downstream accept
//   busy       out                       high while a packet owns the link
//   pkt_count  out  [16]                 completed packets, wraps to 0
//
// ID_WIDTH must equal ceil(log2(NUM_REQ)); NUM_REQ ranges over 2..16.
// -----------------------------------------------------------------------------
module ab_link_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic [ID_WIDTH-1:0]           out_src,
    input  logic                          out_ready,
    output logic                          busy,
    output logic [15:0]                   pkt_count
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [ID_WIDTH-1:0]   r_owner;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic [ID_WIDTH-1:0]   r_out_src;
    logic [15:0]           r_pkt_count;

    logic [ID_WIDTH-1:0]   w_grant;
    int                    w_pos;
    logic                  w_any_valid;
    logic                  w_own_valid;
    logic                  w_own_last;
    logic [DATA_WIDTH-1:0] w_own_data;
    logic                  w_can_load;
    logic                  w_take;
    logic                  w_take_last;
    logic [ID_WIDTH-1:0]   w_rr_next;

    // Round-robin search: walk offsets from the highest down to zero so the
    // closest set index at or above r_rr_ptr is the last one written.
    // NOTE: every signal driven from always_comb gets a default on entry so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_grant = r_rr_ptr;
        w_pos   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = int'(r_rr_ptr) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (req_valid[w_pos[ID_WIDTH-1:0]]) begin
                w_grant = w_pos[ID_WIDTH-1:0];
            end
        end
    end

    assign w_any_valid = |req_valid;

    // Select the owner's beat with constant indices only.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == ID_WIDTH'(i)) begin
                w_own_valid = req_valid[i];
                w_own_last  = req_last[i];
                w_own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The output slot can take a beat when empty or when being drained this
    // cycle, which gives full throughput inside a packet.
    assign w_can_load  = !r_out_valid || out_ready;
    assign w_take      = (r_state == ST_LOCKED) && w_own_valid && w_can_load;
    assign w_take_last = w_take && w_own_last;
    assign w_rr_next   = (r_owner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((r_state == ST_LOCKED) && (r_owner == ID_WIDTH'(i))) begin
                req_ready[i] = w_can_load;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_take_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
            r_pkt_count <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_any_valid) begin
                r_owner <= w_grant;
            end

            if (w_take_last) begin
                r_rr_ptr    <= w_rr_next;
                r_pkt_count <= r_pkt_count + 16'd1;
            end

            // Load has priority over drain: a simultaneous accept and load
            // simply replaces the beat and keeps out_valid high.
            if (w_take) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_own_data;
                r_out_last  <= w_own_last;
                r_out_src   <= r_owner;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;
    assign busy      = (r_state == ST_LOCKED);
    assign pkt_count = r_pkt_count;

endmodule
